// File: rtl/axis_pattern_gen_mc.sv
// Multi-channel AXI4-Stream packet pattern generator: round-robin over enabled
// channels, programmable length/count/pattern, graceful stop and full backpressure.
module axis_pattern_gen_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    ctrl_start,
  input  logic                    ctrl_stop,
  input  logic [1:0]              ctrl_mode,
  input  logic [NUM_CH-1:0]       ctrl_ch_en,
  input  logic [LEN_WIDTH-1:0]    ctrl_pkt_len,
  input  logic [15:0]             ctrl_pkt_count,
  input  logic [DATA_WIDTH-1:0]   ctrl_seed,
  output logic                    status_busy,
  output logic                    status_done,
  output logic [31:0]             status_pkts_sent,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic [ID_WIDTH-1:0]     M_AXIS_TID,
  output logic [DEST_WIDTH-1:0]   M_AXIS_TDEST,
  output logic [USER_WIDTH-1:0]   M_AXIS_TUSER
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q;
  logic [LEN_WIDTH-1:0]    len_q, beat_q;
  logic [15:0]             count_q;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic [NUM_CH-1:0]       chen_q;
  logic [CH_W-1:0]         ch_q;
  logic [USER_WIDTH-1:0]   seq_q;
  logic                    stop_pend;
  logic                    hs, last_hs, end_run, load;
  logic [31:0]             sent_inc;

  // Next enabled channel strictly above c, wrapping; c = NUM_CH-1 yields the lowest.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c,
                                               input logic [NUM_CH-1:0] en);
    logic [CH_W-1:0]   r;
    logic [NUM_CH-1:0] sh;
    logic              found;
    int                idx;
    r = c;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(c) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sh = en >> idx;
      if (!found && sh[0]) begin
        r = CH_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] m,
                                                input logic [DATA_WIDTH-1:0] s,
                                                input logic [LEN_WIDTH-1:0] b);
    case (m)
      2'd1:    return DATA_WIDTH'(1) << (32'(b) % DATA_WIDTH);
      2'd2:    return s;
      default: return s + DATA_WIDTH'(b);
    endcase
  endfunction

  assign hs       = M_AXIS_TVALID & M_AXIS_TREADY;
  assign last_hs  = hs & M_AXIS_TLAST;
  assign sent_inc = (status_pkts_sent == '1) ? status_pkts_sent : status_pkts_sent + 32'd1;
  // A stop arriving on the closing handshake itself also ends the run.
  assign end_run  = last_hs && (((count_q != 16'd0) && (sent_inc == {16'd0, count_q}))
                                || stop_pend || ctrl_stop);
  assign load     = (state_q == SEND) && (!M_AXIS_TVALID || hs) && !end_run;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_start) state_d = (|ctrl_ch_en) ? SEND : FINISH;
      SEND:    if (end_run) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mode_q           <= '0;
      len_q            <= '0;
      count_q          <= '0;
      seed_q           <= '0;
      chen_q           <= '0;
      ch_q             <= '0;
      beat_q           <= '0;
      seq_q            <= '0;
      stop_pend        <= 1'b0;
      status_busy      <= 1'b0;
      status_done      <= 1'b0;
      status_pkts_sent <= '0;
      M_AXIS_TVALID    <= 1'b0;
      M_AXIS_TDATA     <= '0;
      M_AXIS_TSTRB     <= '0;
      M_AXIS_TKEEP     <= '0;
      M_AXIS_TLAST     <= 1'b0;
      M_AXIS_TID       <= '0;
      M_AXIS_TDEST     <= '0;
      M_AXIS_TUSER     <= '0;
    end else begin
      status_busy <= (state_d != IDLE);
      status_done <= (state_d == FINISH);
      if (state_q == IDLE && ctrl_start) begin
        mode_q           <= ctrl_mode;
        len_q            <= ctrl_pkt_len;
        count_q          <= ctrl_pkt_count;
        seed_q           <= ctrl_seed;
        chen_q           <= ctrl_ch_en;
        ch_q             <= next_ch(CH_W'(NUM_CH - 1), ctrl_ch_en);
        beat_q           <= '0;
        seq_q            <= '0;
        stop_pend        <= 1'b0;
        status_pkts_sent <= '0;
      end
      if (state_q == SEND && ctrl_stop) stop_pend <= 1'b1;
      if (last_hs) status_pkts_sent <= sent_inc;
      // Beat counters always point at the next beat to present.
      if (load) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= pat(mode_q, seed_q, beat_q);
        M_AXIS_TLAST  <= (beat_q == len_q);
        M_AXIS_TID    <= ID_WIDTH'(ch_q);
        M_AXIS_TDEST  <= DEST_WIDTH'(ch_q);
        M_AXIS_TUSER  <= seq_q;
        M_AXIS_TSTRB  <= '1;
        M_AXIS_TKEEP  <= '1;
        if (beat_q == len_q) begin
          beat_q <= '0;
          ch_q   <= next_ch(ch_q, chen_q);
          seq_q  <= seq_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end else if (hs) begin
        M_AXIS_TVALID <= 1'b0;
        M_AXIS_TLAST  <= 1'b0;
        M_AXIS_TSTRB  <= '0;
        M_AXIS_TKEEP  <= '0;
      end
    end
  end

endmodule
